// File: rtl/prod_accum_pkg.sv
// Shared widths and state encoding for the product accumulator.
// The sum width is derived so that a full batch of extreme products cannot wrap.
package prod_accum_pkg;

  localparam int PA_PW = 65;
  localparam int PA_CW = 8;
  localparam int PA_SW = PA_PW + PA_CW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum.sv
// Batch accumulator for signed products from a multiplier pipeline.
// It sums a counted batch, then holds the result until the downstream accepts it.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PW = PA_PW,
  parameter int CW = PA_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prod_valid,
  input  logic [PW-1:0]    prod,
  input  logic             start,
  input  logic [CW-1:0]    len,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [PW+CW-1:0] sum,
  output logic             busy,
  output logic             overrun
);

  localparam int SW = PW + CW;
  // Remaining count needs one extra bit so that len=0 can stand for 2^CW.
  localparam logic [CW:0] REM_ONE  = (CW+1)'(1);
  localparam logic [CW:0] REM_FULL = {1'b1, {CW{1'b0}}};

  state_t        r_state;
  state_t        w_state_next;
  logic [SW-1:0] r_acc;
  logic [SW-1:0] r_sum;
  logic [CW:0]   r_rem;
  logic          r_overrun;

  logic [SW-1:0] w_prod_ext;
  logic [SW-1:0] w_acc_sum;
  logic          w_last;

  assign w_prod_ext = {{CW{prod[PW-1]}}, prod};
  assign w_acc_sum  = r_acc + w_prod_ext;
  assign w_last     = (r_rem == REM_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start)                w_state_next = ST_ACC;
      ST_ACC:  if (prod_valid && w_last) w_state_next = ST_HOLD;
      ST_HOLD: if (sum_ready)            w_state_next = ST_IDLE;
      default:                           w_state_next = ST_IDLE;
    endcase
  end

  // sum_valid is decoded from registered state only, so no input reaches it combinationally.
  always_comb begin
    busy      = (r_state != ST_IDLE);
    sum_valid = (r_state == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_sum     <= '0;
      r_rem     <= '0;
      r_overrun <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rem     <= (len == '0) ? REM_FULL : {1'b0, len};
            r_acc     <= '0;
            r_overrun <= 1'b0;
          end
        end
        ST_ACC: begin
          if (prod_valid) begin
            r_acc <= w_acc_sum;
            r_rem <= r_rem - REM_ONE;
            if (w_last) r_sum <= w_acc_sum;
          end
        end
        ST_HOLD: begin
          if (prod_valid) r_overrun <= 1'b1;
        end
        default: begin
          r_overrun <= r_overrun;
        end
      endcase
    end
  end

  assign sum     = r_sum;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: directed batches plus random traffic,
// compared every cycle against a batch-level behavioural model.
module tb_prod_accum;
  import prod_accum_pkg::*;

  localparam int PW = PA_PW;
  localparam int CW = PA_CW;
  localparam int SW = PA_SW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 prod_valid = 1'b0;
  logic signed [PW-1:0] prod = '0;
  logic                 start = 1'b0;
  logic [CW-1:0]        len = '0;
  logic                 sum_valid;
  logic                 sum_ready = 1'b0;
  logic [SW-1:0]        sum;
  logic                 busy;
  logic                 overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  prod_accum #(.PW(PW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (prod_valid),
    .prod       (prod),
    .start      (start),
    .len        (len),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum        (sum),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Behavioural model: a batch is either being collected, or finished and waiting.
  logic                 m_collecting;
  logic                 m_pending;
  int                   m_left;
  logic signed [SW-1:0] m_acc;
  logic signed [SW-1:0] m_sum;
  logic                 m_ovr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_collecting = 1'b0;
      m_pending    = 1'b0;
      m_left       = 0;
      m_acc        = '0;
      m_sum        = '0;
      m_ovr        = 1'b0;
    end else if (m_pending) begin
      if (prod_valid) m_ovr = 1'b1;
      if (sum_ready)  m_pending = 1'b0;
    end else if (m_collecting) begin
      if (prod_valid) begin
        m_acc  = m_acc + prod;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_sum        = m_acc;
          m_collecting = 1'b0;
          m_pending    = 1'b1;
        end
      end
    end else if (start) begin
      m_left       = (len == 0) ? (1 << CW) : int'(len);
      m_acc        = '0;
      m_ovr        = 1'b0;
      m_collecting = 1'b1;
    end
  end

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("sum_valid", SW'(sum_valid), SW'(m_pending));
      check("sum",       sum,            m_sum);
      check("busy",      SW'(busy),      SW'(m_collecting | m_pending));
      check("overrun",   SW'(overrun),   SW'(m_ovr));
    end
  end

  task automatic cyc(input logic pv, input logic signed [PW-1:0] p, input logic st,
                     input logic [CW-1:0] l, input logic rdy);
    prod_valid = pv;
    prod       = p;
    start      = st;
    len        = l;
    sum_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rand_prod();
    logic [95:0] tmp;
    tmp = {$urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       return 65'h0_FFFF_FFFF_FFFF_FFFF;
      1:       return 65'h1_0000_0000_0000_0000;
      2:       return '1;
      3:       return '0;
      default: return tmp[PW-1:0];
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_sum_valid", SW'(sum_valid), '0);
    check("rst_sum",       sum,            '0);
    check("rst_busy",      SW'(busy),      '0);
    check("rst_overrun",   SW'(overrun),   '0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // Basic batch of four products.
    cyc(0, 0, 1, 4, 0);
    for (int i = 1; i <= 4; i++) cyc(1, PW'(i), 0, 0, 0);
    check("t1_valid", SW'(sum_valid), SW'(1));
    check("t1_sum",   sum,            SW'(10));
    check("t1_model", m_sum,          SW'(10));
    cyc(0, 0, 0, 0, 1);
    check("t1_idle", SW'(busy), '0);

    // Gaps and mixed signs.
    cyc(0, 0, 1, 3, 0);
    cyc(1, -5, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("t2_busy_gap", SW'(busy), SW'(1));
    cyc(0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    check("t2_busy", SW'(busy), SW'(1));
    cyc(1, -7, 0, 0, 0);
    check("t2_sum",   sum,   73'h1_FFFF_FFFF_FFFF_FFFF_F7);
    check("t2_model", m_sum, 73'h1_FFFF_FFFF_FFFF_FFFF_F7);
    cyc(0, 0, 0, 0, 1);

    // Full-length batch of maximum positive products.
    cyc(0, 0, 1, 0, 0);
    repeat (256) cyc(1, 65'h0_FFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    check("t3_valid", SW'(sum_valid), SW'(1));
    check("t3_sum",   sum,            73'h0_FFFF_FFFF_FFFF_FFFF_00);
    cyc(0, 0, 0, 0, 1);

    // Full-length batch of most negative products.
    cyc(0, 0, 1, 0, 0);
    repeat (256) cyc(1, 65'h1_0000_0000_0000_0000, 0, 0, 0);
    check("t4_sum", sum, 73'h1_0000_0000_0000_0000_00);
    cyc(0, 0, 0, 0, 1);

    // Backpressure with a dropped product.
    cyc(0, 0, 1, 2, 0);
    cyc(1, 7, 0, 0, 0);
    cyc(1, 8, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc((i == 2), 99, 0, 0, 0);
    check("t5_hold_sum",   sum,          SW'(15));
    check("t5_hold_valid", SW'(sum_valid), SW'(1));
    check("t5_overrun",    SW'(overrun),   SW'(1));
    cyc(0, 0, 0, 0, 1);
    check("t5_idle",        SW'(busy),    '0);
    check("t5_sum_retain",  sum,          SW'(15));
    check("t5_ovr_sticky",  SW'(overrun), SW'(1));
    cyc(0, 0, 1, 1, 0);
    check("t5_ovr_clear", SW'(overrun), '0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);

    // Asynchronous reset mid-batch.
    cyc(0, 0, 1, 4, 0);
    cyc(1, 5, 0, 0, 0);
    cyc(1, 6, 0, 0, 0);
    prod_valid = 1'b1;
    prod = 7;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",  SW'(busy),      '0);
    check("t6_rst_sum",   sum,            '0);
    check("t6_rst_valid", SW'(sum_valid), '0);
    check("t6_rst_ovr",   SW'(overrun),   '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 1, 1, 0);
    cyc(1, 9, 0, 0, 0);
    check("t6_sum9", sum, SW'(9));
    cyc(0, 0, 0, 0, 1);

    // Start during a batch and at the handshake is ignored.
    cyc(0, 0, 1, 3, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 2, 1, 1, 0);
    check("t7_no_reload", SW'(sum_valid), '0);
    cyc(1, 3, 0, 0, 0);
    check("t7_sum", sum, SW'(6));
    cyc(0, 0, 1, 2, 1);
    check("t7_hs_start", SW'(busy), '0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic          st;
      logic [CW-1:0] l;
      st = ($urandom_range(0, 7) == 0);
      l  = ($urandom_range(0, 15) == 0) ? CW'(0) : CW'($urandom_range(1, 6));
      if ($urandom_range(0, 999) == 0) begin
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      cyc(($urandom_range(0, 9) < 6), rand_prod(), st, l, ($urandom_range(0, 9) < 3));
    end

    cyc(0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter PW, default 65, width of the signed product word from the upstream Booth multiplier pipeline.
REQ-002 Parameter CW, default 8, width of the batch-length field; a batch holds at most 2^CW products.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 prod_valid  input  1  product qualifier, one pulse per product from the multiplier pipeline.
REQ-006 prod  input  PW  signed two's-complement product, sampled only when prod_valid=1.
REQ-007 start  input  1  single-cycle batch start request.
REQ-008 len  input  CW  batch length, sampled with start; 0 encodes 2^CW.
REQ-009 sum_valid  output  1  accumulated sum available.
REQ-010 sum_ready  input  1  downstream accepts sum.
REQ-011 sum  output  PW+CW  signed batch sum.
REQ-012 busy  output  1  high in states ACC and HOLD.
REQ-013 overrun  output  1  sticky flag: a product arrived in HOLD and was dropped.

Function
REQ-014 States SHALL be IDLE, ACC and HOLD.
REQ-015 IDLE: start=1 SHALL load remaining=len (0 means 2^CW), clear the accumulator and overrun, and move to ACC.
REQ-016 IDLE: prod_valid SHALL be ignored, with no flag.
REQ-017 ACC: each cycle with prod_valid=1 SHALL add the sign-extended prod to the accumulator and decrement remaining.
REQ-018 ACC: gaps (prod_valid=0) SHALL leave all state unchanged.
REQ-019 ACC: the edge that samples the final product SHALL register sum=accumulator+prod, assert sum_valid and enter HOLD, so sum_valid rises one cycle after the final prod_valid.
REQ-020 Accumulator and sum SHALL be PW+CW bits wide, so 2^CW extreme products never wrap; no saturation logic.
REQ-021 HOLD: sum and sum_valid SHALL remain stable until a cycle with sum_valid=1 and sum_ready=1, after which the state is IDLE and sum_valid=0.
REQ-022 HOLD: prod_valid=1 SHALL drop the product and set overrun=1.
REQ-023 overrun SHALL stay set until the next accepted start.
REQ-024 start SHALL be ignored in ACC and HOLD, including a start coincident with the HOLD handshake; len is not re-sampled.
REQ-025 sum_ready SHALL be ignored outside HOLD.
REQ-026 sum SHALL retain its last value after the handshake until the next batch completes.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, accumulator=0, remaining=0, sum=0, sum_valid=0, busy=0 and overrun=0, regardless of clk.
REQ-028 Reset asserted mid-batch SHALL discard the partial sum.
REQ-029 After rst_n rises, the first start SHALL be honoured on the next clock edge.

Structure
REQ-030 A shared package SHALL hold PW, CW, the derived sum width PW+CW and the three-value state enumeration.
REQ-031 The block SHALL be a single module with no sub-module; adder, counter and state register stay local.
REQ-032 There SHALL be no combinational path from prod, prod_valid or sum_ready to sum or sum_valid.

Verification
REQ-033 Basic batch: start with len=4, then products 1,2,3,4 on consecutive cycles -> sum_valid rises the cycle after product 4, with sum=10.
REQ-034 Gaps and signs: len=3, products -5, (2 idle cycles), 3, -7 -> sum=-9 as 73-bit two's complement (0x1_FFFF_FFFF_FFFF_FFFF_F7); busy=1 throughout.
REQ-035 Length boundary, positive: len=0 with 256 products of 2^64-1 -> sum=256*(2^64-1), no wrap.
REQ-036 Length boundary, negative: len=0 with 256 products of -2^64 -> sum=-2^72.
REQ-037 Backpressure: sum_ready=0 for 5 cycles in HOLD with one prod_valid pulse -> sum constant and overrun=1; then sum_ready=1 -> IDLE; next start -> overrun=0.
REQ-038 Reset and ignored start: rst_n=0 after 2 of 4 products -> all outputs 0 asynchronously; start with len=1, product 9 -> sum=9; a start pulse during ACC does not alter remaining.
